// File: rtl/dispatcher_pkg.sv
// dispatcher_pkg: types and constants shared by the dispatcher blocks
// (register status table, tag free-list FIFO, CDB).
//   TAG_W       - rename tag width, common to free-list and CDB
//   REG_ADDR_W  - architectural register address width
//   tag_t       - rename tag
//   rst_entry_t - one register status entry {busy, tag}
package dispatcher_pkg;

   localparam int unsigned TAG_W      = 6;
   localparam int unsigned REG_ADDR_W = 5;

   typedef logic [TAG_W-1:0] tag_t;

   typedef struct packed {
      logic busy;
      tag_t tag;
   } rst_entry_t;

endpackage

// File: rtl/rst_lookup.sv
// rst_lookup: one source-operand read port of the register status table.
// Ports:
//   addr      - register to look up
//   tbl       - current table contents (registered state)
//   cdb_valid - CDB broadcast valid this cycle
//   cdb_tag   - CDB broadcast tag
//   busy      - source pending
//   tag       - producing tag when busy, 0 otherwise
// Config macro: RST_CDB_BYPASS_EN - when defined, a broadcast matching the
// looked-up entry is reported as already cleared in the same cycle.
module rst_lookup
   import dispatcher_pkg::*;
#(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic [ADDR_W-1:0]           addr,
   input  rst_entry_t [NUM_REGS-1:0]   tbl,
   input  logic                        cdb_valid,
   input  tag_t                        cdb_tag,
   output logic                        busy,
   output tag_t                        tag
);

   rst_entry_t entry;

   always_comb begin
      entry = tbl[addr];
      busy  = entry.busy & (addr != '0);
`ifdef RST_CDB_BYPASS_EN
      if (cdb_valid && entry.tag == cdb_tag) begin
         busy = 1'b0;
      end
`else
      // Broadcast only takes effect at the next edge; the reservation
      // station snoops the CDB to cover this cycle.
      if (cdb_valid && 1'b0) begin
         busy = 1'b0;
      end
`endif
      tag = busy ? entry.tag : '0;
   end

endmodule

// File: rtl/reg_status_table.sv
// reg_status_table: per-register pending/tag table for the dispatcher.
// Allocates a free-list tag to the destination of each dispatched writer,
// clears entries on matching CDB broadcasts and serves two source lookups.
// Ports:
//   clk, rst                   - clock, async active-high reset
//   disp_valid/rd_wr/rd        - dispatched instruction and its destination
//   rs1_addr/rs2_addr          - source lookups -> rs*_busy, rs*_tag
//   fl_tag, fl_empty, fl_pull  - tag free-list FIFO head/empty/pop
//   disp_tag, disp_stall       - allocated tag, stall for empty free-list
//   cdb_valid, cdb_tag         - completion broadcast
//   busy_count                 - number of busy entries (registered)
// Config macro: RST_CDB_BYPASS_EN (same-cycle CDB bypass on lookups).
module reg_status_table
   import dispatcher_pkg::*;
#(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned TAG_W    = dispatcher_pkg::TAG_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          disp_valid,
   input  logic                          disp_rd_wr,
   input  logic [$clog2(NUM_REGS)-1:0]   disp_rd,
   input  logic [$clog2(NUM_REGS)-1:0]   rs1_addr,
   input  logic [$clog2(NUM_REGS)-1:0]   rs2_addr,
   output logic                          rs1_busy,
   output logic                          rs2_busy,
   output logic [TAG_W-1:0]              rs1_tag,
   output logic [TAG_W-1:0]              rs2_tag,
   input  logic [TAG_W-1:0]              fl_tag,
   input  logic                          fl_empty,
   output logic                          fl_pull,
   output logic [TAG_W-1:0]              disp_tag,
   output logic                          disp_stall,
   input  logic                          cdb_valid,
   input  logic [TAG_W-1:0]              cdb_tag,
   output logic [$clog2(NUM_REGS):0]     busy_count
);

   localparam int unsigned ADDR_W = $clog2(NUM_REGS);
   localparam int unsigned CNT_W  = ADDR_W + 1;

   rst_entry_t [NUM_REGS-1:0] tbl;
   logic                      alloc;
   logic [NUM_REGS-1:0]       clr_vec;
   logic [CNT_W-1:0]          clr_cnt;
   logic                      inc;

   always_comb begin
      alloc      = !rst && disp_valid && disp_rd_wr && (disp_rd != '0);
      fl_pull    = alloc && !fl_empty;
      disp_stall = alloc && fl_empty;
      disp_tag   = fl_pull ? fl_tag : '0;
      inc        = fl_pull && !tbl[disp_rd].busy;
   end

   // An entry both cleared and re-allocated stays busy, so it is left out
   // of the clear count.
   always_comb begin
      clr_vec = '0;
      clr_cnt = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (cdb_valid && tbl[i].busy && tbl[i].tag == cdb_tag) begin
            clr_vec[i] = 1'b1;
            if (!(fl_pull && disp_rd == ADDR_W'(i))) begin
               clr_cnt = clr_cnt + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tbl        <= '0;
         busy_count <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (clr_vec[i]) begin
               tbl[i].busy <= 1'b0;
            end
         end
         // Later assignment: allocation wins over a same-cycle clear.
         if (fl_pull) begin
            tbl[disp_rd] <= rst_entry_t'{busy: 1'b1, tag: fl_tag};
         end
         busy_count <= busy_count + CNT_W'(inc) - clr_cnt;
      end
   end

   rst_lookup #(.NUM_REGS(NUM_REGS)) u_lookup_rs1 (
      .addr      (rs1_addr),
      .tbl       (tbl),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .busy      (rs1_busy),
      .tag       (rs1_tag)
   );

   rst_lookup #(.NUM_REGS(NUM_REGS)) u_lookup_rs2 (
      .addr      (rs2_addr),
      .tbl       (tbl),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .busy      (rs2_busy),
      .tag       (rs2_tag)
   );

endmodule

// File: doc/reg_status_table.md
# reg_status_table

Register Status Table (RST) for the dispatcher. Tracks, per architectural register, whether its value is pending and which tag will produce it. On dispatch of an instruction that writes a register, it takes the next free tag from the tag free-list FIFO and records it against the destination. On a CDB broadcast it clears every entry still waiting on the broadcast tag. It provides source-operand lookups to the reservation-station allocation logic.

## Interface
- NUM_REGS, 32, number of architectural registers (power of two)
- TAG_W, 6, tag width; must match free-list FIFO tag width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- disp_valid  in  1  instruction presented for dispatch this cycle
- disp_rd_wr  in  1  instruction writes a destination register
- disp_rd  in  $clog2(NUM_REGS)  destination register
- rs1_addr, rs2_addr  in  $clog2(NUM_REGS)  source registers to look up
- rs1_busy, rs2_busy  out  1  source pending (value not yet in register file)
- rs1_tag, rs2_tag  out  TAG_W  producing tag when busy; 0 when not busy
- fl_tag  in  TAG_W  head tag of free-list FIFO (its tag_out)
- fl_empty  in  1  free-list FIFO empty
- fl_pull  out  1  pop free-list head this cycle
- disp_tag  out  TAG_W  tag allocated to the destination (= fl_tag when fl_pull)
- disp_stall  out  1  dispatch cannot proceed (needs tag, free-list empty)
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- busy_count  out  $clog2(NUM_REGS)+1  number of busy entries

## Operation
- Each entry holds busy (1 bit) and tag (TAG_W).
- Define alloc = disp_valid & disp_rd_wr & (disp_rd != 0).
- fl_pull = alloc & !fl_empty, and disp_stall = alloc & fl_empty. Both are combinational.
- On fl_pull, at the clock edge: entry[disp_rd] <= {busy=1, tag=fl_tag}.
- On cdb_valid, at the clock edge: every entry with busy=1 and tag==cdb_tag gets busy <= 0.
- Simultaneous allocation and CDB clear of the same register: the allocation wins, and the entry holds the new tag busy.
- Register 0 is never allocated. rs lookups of 0 always return busy=0, tag=0.
- Lookup is combinational from the current table contents (read-before-write).
  - With disp_rd == rs1_addr in the same cycle, rs1 sees the old mapping.
- busy_count is registered and updated by (+1 if the allocation lands on a non-busy entry) minus (number of entries cleared by the CDB this cycle).
  - Do not double-count when the allocation targets an entry the CDB is clearing.
- Nothing is done with fl_tag unless fl_pull. cdb_tag matching no entry is a no-op.

## Timing
- Reset: all busy=0, all tag=0, busy_count=0.
- Outputs under reset: fl_pull=0, disp_stall=0, rs*_busy=0, rs*_tag=0, disp_tag=0.
- Reset asserted mid-operation discards all mappings immediately (asynchronous). The free-list is reset in the same event.
- Allocation is visible to lookups the cycle after fl_pull. The CDB clear is likewise visible the cycle after cdb_valid (without the macro).
- The free-list FIFO sees fl_pull as its tag_pull in the same cycle; fl_tag is stable throughout that cycle.
- A stalled dispatch leaves the table unchanged. Upstream holds the instruction.

## Configuration
- RST_CDB_BYPASS_EN defined: if cdb_valid and the looked-up entry is busy with tag==cdb_tag this cycle, the lookup returns busy=0, tag=0 in the same cycle.
- RST_CDB_BYPASS_EN undefined: lookups reflect registered state only. There is a one-cycle window where the source reads as busy on a tag just broadcast, so the reservation station must snoop the CDB itself.

## Structure
- Shared package dispatcher_pkg holds:
  - TAG_W and REG_ADDR_W constants;
  - rst_entry_t struct {busy, tag};
  - the tag type shared with the free-list FIFO and the CDB.
- Sub-module rst_lookup: one read port (address, table, CDB inputs → busy, tag), including the optional bypass. Instantiated twice.

## Test plan
- Reset, then look up r5 → busy=0, tag=0; busy_count=0.
- Dispatch rd=5 with fl_tag=0 → fl_pull=1. Next cycle rs1_addr=5 → busy=1, tag=0; busy_count=1.
- Rename r5 again with tag=1, then broadcast cdb_tag=0 → r5 stays busy with tag 1. Then cdb_tag=1 → r5 clears; busy_count=0.
- Dispatch rd=0 → fl_pull=0 and table unchanged. Dispatch rd=7 with fl_empty=1 → disp_stall=1, fl_pull=0, and r7 is not busy next cycle.
- Same cycle: dispatch rd=3 with tag 9 and CDB clears r3's old tag 4 → r3 busy with tag 9. busy_count is unchanged.
- With RST_CDB_BYPASS_EN: r2 busy with tag 12, cdb_tag=12 and rs2_addr=2 in the same cycle → rs2_busy=0 that cycle. Without the macro → rs2_busy=1, then 0 the next cycle.
